util_axis_byte_to_word: RTL and testbench

Packs a stream of bytes from the upstream `util_axis_tiny_fifo` master port into wider words for the 1553 word-level stages downstream. Every WORD_BYTES accepted bytes become one output word, ordered MSB-first by default to match 1553 bit order. Full-throughput AXIS on both sides with a single registered output stage. A synchronous clear discards a partially assembled word.

---
 rtl/util_axis_tiny_fifo.sv | 52 +++++
 rtl/util_axis_byte_to_word.sv | 103 ++++++++++
 tb/tb_util_axis_byte_to_word.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/util_axis_tiny_fifo.sv
// Two-entry AXI-Stream FIFO with registered storage; upstream neighbour of the
// byte-to-word packer.
module util_axis_tiny_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic [WIDTH-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign s_axis_tready = (count_q != 2'd2);
    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign push          = s_axis_tvalid & s_axis_tready;
    assign pop           = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_axis_tdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/util_axis_byte_to_word.sv
// Packs WORD_BYTES consecutive stream bytes into one output word through a
// single registered output stage; clr drops a partially assembled word.
module util_axis_byte_to_word #(
    parameter int BYTE_WIDTH = 8,
    parameter int WORD_BYTES = 2,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                             aclk,
    input  logic                             arst,
    input  logic                             clr,
    input  logic [BYTE_WIDTH-1:0]            s_axis_tdata,
    input  logic                             s_axis_tvalid,
    output logic                             s_axis_tready,
    output logic [BYTE_WIDTH*WORD_BYTES-1:0] m_axis_tdata,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             partial
);

    localparam int WORD_WIDTH = BYTE_WIDTH * WORD_BYTES;
    localparam int ACC_WIDTH  = BYTE_WIDTH * (WORD_BYTES - 1);
    localparam int CNT_WIDTH  = $clog2(WORD_BYTES);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(WORD_BYTES - 1);

    if (WORD_BYTES < 2 || WORD_BYTES > 8) begin : g_bad_word_bytes
        $error("util_axis_byte_to_word: WORD_BYTES must be within 2..8");
    end

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  vld_q, vld_d;
    logic [WORD_WIDTH-1:0] word_asm;
    logic                  accept;
    logic                  load;

    // Output byte lane that receives the k-th byte of a word.
    function automatic int lane(input int k);
        return BIG_ENDIAN ? (WORD_BYTES - 1 - k) : k;
    endfunction

    assign s_axis_tready = (cnt_q != LAST) | ~vld_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load          = accept & ~clr & (cnt_q == LAST);
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = vld_q;
    assign partial       = (cnt_q != '0);

    always_comb begin
        word_asm = '0;
        for (int k = 0; k < WORD_BYTES - 1; k++) begin
            word_asm[lane(k)*BYTE_WIDTH +: BYTE_WIDTH] = acc_q[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
        word_asm[lane(WORD_BYTES-1)*BYTE_WIDTH +: BYTE_WIDTH] = s_axis_tdata;
    end

    // clr wins over a byte accepted in the same cycle: that byte is dropped.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
            end else begin
                for (int k = 0; k < WORD_BYTES - 1; k++) begin
                    if (cnt_q == CNT_WIDTH'(k)) begin
                        acc_d[k*BYTE_WIDTH +: BYTE_WIDTH] = s_axis_tdata;
                    end
                end
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (load) begin
            data_d = word_asm;
            vld_d  = 1'b1;
        end else if (m_axis_tready) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

endmodule

// File: tb/tb_util_axis_byte_to_word.sv
// Bench for util_axis_byte_to_word: cycle vector table, little-endian 4-byte
// instance, reset corners, and random traffic through util_axis_tiny_fifo.
module tb_util_axis_byte_to_word;

    logic        aclk = 1'b0;
    logic        arst;
    logic        clr;
    logic        use_fifo;
    logic        drv_tvalid;
    logic [7:0]  drv_tdata;
    logic        up_tvalid;
    logic [7:0]  up_tdata;
    logic        fifo_s_tready;
    logic [7:0]  fifo_m_tdata;
    logic        fifo_m_tvalid;
    logic        fifo_m_tready;
    logic        dut_s_tvalid;
    logic [7:0]  dut_s_tdata;
    logic        dut_s_tready;
    logic [15:0] dut_m_tdata;
    logic        dut_m_tvalid;
    logic        dut_m_tready;
    logic        dut_partial;
    logic        le_clr;
    logic        le_tvalid;
    logic [7:0]  le_tdata;
    logic        le_s_tready;
    logic [31:0] le_m_tdata;
    logic        le_m_tvalid;
    logic        le_m_tready;
    logic        le_partial;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] le_got[$];

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        mr;
        logic        c;
        logic        e_sr;
        logic        e_mv;
        logic [15:0] e_md;
        logic        e_p;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    // ---------------- DUTs and upstream neighbour ----------------
    assign dut_s_tvalid  = use_fifo ? fifo_m_tvalid : drv_tvalid;
    assign dut_s_tdata   = use_fifo ? fifo_m_tdata  : drv_tdata;
    assign fifo_m_tready = use_fifo & dut_s_tready;

    util_axis_tiny_fifo #(.WIDTH(8)) u_fifo (
        .aclk          (aclk),
        .arst          (arst),
        .s_axis_tdata  (up_tdata),
        .s_axis_tvalid (up_tvalid),
        .s_axis_tready (fifo_s_tready),
        .m_axis_tdata  (fifo_m_tdata),
        .m_axis_tvalid (fifo_m_tvalid),
        .m_axis_tready (fifo_m_tready)
    );

    util_axis_byte_to_word dut (
        .aclk          (aclk),
        .arst          (arst),
        .clr           (clr),
        .s_axis_tdata  (dut_s_tdata),
        .s_axis_tvalid (dut_s_tvalid),
        .s_axis_tready (dut_s_tready),
        .m_axis_tdata  (dut_m_tdata),
        .m_axis_tvalid (dut_m_tvalid),
        .m_axis_tready (dut_m_tready),
        .partial       (dut_partial)
    );

    util_axis_byte_to_word #(.BYTE_WIDTH(8), .WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut_le (
        .aclk          (aclk),
        .arst          (arst),
        .clr           (le_clr),
        .s_axis_tdata  (le_tdata),
        .s_axis_tvalid (le_tvalid),
        .s_axis_tready (le_s_tready),
        .m_axis_tdata  (le_m_tdata),
        .m_axis_tvalid (le_m_tvalid),
        .m_axis_tready (le_m_tready),
        .partial       (le_partial)
    );

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_byte(input logic v, input logic [7:0] d, input logic mr);
        @(negedge aclk);
        drv_tvalid   = v;
        drv_tdata    = d;
        dut_m_tready = mr;
    endtask

    // Reference: the k-th accepted byte pair forms one big-endian word.
    task automatic model_push_byte(input logic [7:0] b);
        byte_q.push_back(b);
        if (byte_q.size() == 2) begin
            exp_q.push_back({byte_q[0], byte_q[1]});
            byte_q.delete();
        end
    endtask

    initial begin
        //                v     d      mr    clr   sr    mv    md        p
        vecs[0]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 8'h56, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0};
        vecs[3]  = '{1'b1, 8'h78, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5678, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b0};
        vecs[6]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b0};
        vecs[7]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 1'b0, 16'h5678, 1'b1};
        vecs[8]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 16'hAABB, 1'b0};
        vecs[9]  = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAABB, 1'b1};
        vecs[10] = '{1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 1'b1, 16'hAABB, 1'b1};
        vecs[11] = '{1'b1, 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 16'hAABB, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'hCCDD, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'hCCDD, 1'b0};
        vecs[14] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 16'hCCDD, 1'b0};
        vecs[15] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0, 16'hCCDD, 1'b1};
        vecs[16] = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 16'hCCDD, 1'b0};
        vecs[17] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 16'hCCDD, 1'b1};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h3344, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3344, 1'b0};
    end

    // ---------------- test sequence ----------------
    initial begin : main
        int          sent;
        int          got;
        int          cyc;
        logic        prev_stall;
        logic [15:0] prev_data;
        logic        le_stalled;
        logic [15:0] exp_w;

        arst         = 1'b1;
        clr          = 1'b0;
        use_fifo     = 1'b0;
        drv_tvalid   = 1'b0;
        drv_tdata    = 8'h00;
        dut_m_tready = 1'b1;
        up_tvalid    = 1'b0;
        up_tdata     = 8'h00;
        le_clr       = 1'b0;
        le_tvalid    = 1'b0;
        le_tdata     = 8'h00;
        le_m_tready  = 1'b1;

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_s_tready", 32'(dut_s_tready), 32'h1);
        chk("rst_m_tvalid", 32'(dut_m_tvalid), 32'h0);
        chk("rst_m_tdata",  32'(dut_m_tdata),  32'h0);
        chk("rst_partial",  32'(dut_partial),  32'h0);
        chk("rst_le_tdata", le_m_tdata,        32'h0);
        @(negedge aclk);
        arst = 1'b0;

        // Cycle-by-cycle vector table: expectations are the state seen before each edge.
        for (int i = 0; i < NV; i++) begin
            @(negedge aclk);
            drv_tvalid   = vecs[i].v;
            drv_tdata    = vecs[i].d;
            dut_m_tready = vecs[i].mr;
            clr          = vecs[i].c;
            #1;
            chk($sformatf("v%0d_s_tready", i), 32'(dut_s_tready), 32'(vecs[i].e_sr));
            chk($sformatf("v%0d_m_tvalid", i), 32'(dut_m_tvalid), 32'(vecs[i].e_mv));
            chk($sformatf("v%0d_m_tdata", i),  32'(dut_m_tdata),  32'(vecs[i].e_md));
            chk($sformatf("v%0d_partial", i),  32'(dut_partial),  32'(vecs[i].e_p));
        end
        @(negedge aclk);
        drv_tvalid = 1'b0;
        clr        = 1'b0;

        // Little-endian, 4 bytes per word.
        le_stalled = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            le_tvalid = (i < 8);
            le_tdata  = 8'(i + 1);
            #1;
            if (!le_s_tready) le_stalled = 1'b1;
            if (le_m_tvalid) le_got.push_back(le_m_tdata);
        end
        le_tvalid = 1'b0;
        chk("le_never_stalled", 32'(le_stalled), 32'h0);
        chk("le_word_count", 32'(le_got.size()), 32'd2);
        if (le_got.size() == 2) begin
            chk("le_word0", le_got[0], 32'h04030201);
            chk("le_word1", le_got[1], 32'h08070605);
        end

        // Reset with a word pending and one byte held.
        drive_byte(1'b1, 8'h01, 1'b0);
        drive_byte(1'b1, 8'h02, 1'b0);
        drive_byte(1'b1, 8'h03, 1'b0);
        drive_byte(1'b0, 8'h00, 1'b0);
        #1;
        chk("pre_rst_m_tvalid", 32'(dut_m_tvalid), 32'h1);
        chk("pre_rst_m_tdata",  32'(dut_m_tdata),  32'h0102);
        chk("pre_rst_partial",  32'(dut_partial),  32'h1);
        arst = 1'b1;
        #1;
        chk("async_rst_s_tready", 32'(dut_s_tready), 32'h1);
        chk("async_rst_m_tvalid", 32'(dut_m_tvalid), 32'h0);
        chk("async_rst_m_tdata",  32'(dut_m_tdata),  32'h0);
        chk("async_rst_partial",  32'(dut_partial),  32'h0);
        @(negedge aclk);
        arst = 1'b0;
        drive_byte(1'b1, 8'h55, 1'b1);
        drive_byte(1'b1, 8'h66, 1'b1);
        drive_byte(1'b0, 8'h00, 1'b1);
        #1;
        chk("post_rst_m_tvalid", 32'(dut_m_tvalid), 32'h1);
        chk("post_rst_m_tdata",  32'(dut_m_tdata),  32'h5566);
        @(negedge aclk);

        // Random traffic through the tiny FIFO against the pairing model.
        use_fifo   = 1'b1;
        sent       = 0;
        got        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (cyc = 0; cyc < 20000 && got < 500; cyc++) begin
            @(negedge aclk);
            up_tvalid    = (sent < 1000) && ($urandom_range(0, 1) == 1);
            up_tdata     = 8'(sent);
            dut_m_tready = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                chk("stall_hold_valid", 32'(dut_m_tvalid), 32'h1);
                chk("stall_hold_data",  32'(dut_m_tdata),  32'(prev_data));
            end
            if (up_tvalid && fifo_s_tready) begin
                model_push_byte(up_tdata);
                sent++;
            end
            if (dut_m_tvalid && dut_m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_word", 32'(dut_m_tdata), 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk($sformatf("rand_word%0d", got), 32'(dut_m_tdata), 32'(exp_w));
                end
                got++;
            end
            prev_stall = dut_m_tvalid & ~dut_m_tready;
            prev_data  = dut_m_tdata;
        end
        @(negedge aclk);
        up_tvalid = 1'b0;
        chk("rand_bytes_sent", 32'(sent), 32'd1000);
        chk("rand_words_seen", 32'(got),  32'd500);
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
